// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage hold/clear controls, multi-cycle stall FSM and stall watchdog.
// Optional performance counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_ID,
    input  logic [4:0]  rs2_ID,
    input  logic        rs1_used_ID,
    input  logic        rs2_used_ID,
    input  logic [4:0]  rd_EX,
    input  logic        load_EX,
    input  logic        br_taken_EX,
    input  logic        jal_ID,
    input  logic        dcache_miss,
    input  logic        dcache_done,
    input  logic        div_start_EX,
    input  logic        div_done,
    output logic        bubbleF,
    output logic        bubbleD,
    output logic        bubbleE,
    output logic        bubbleM,
    output logic        bubbleW,
    output logic        flushF,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        stall_err,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned PERF_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MISS = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_err_q, stall_err_d;

    logic miss_stall;
    logic div_stall;
    logic load_use;
    logic any_stall;

    // A done pulse always ends the miss stall, even in the cycle the miss is first seen.
    always_comb begin
        miss_stall = 1'b0;
        div_stall  = 1'b0;
        load_use   = 1'b0;
        if (state_q == ST_MISS) begin
            miss_stall = !dcache_done;
        end else begin
            miss_stall = dcache_miss && !dcache_done;
        end
        div_stall = (((state_q == ST_RUN) && div_start_EX && !dcache_miss) ||
                     (state_q == ST_DIV)) && !div_done;
        load_use  = load_EX && (rd_EX != REG_W'(0)) &&
                    ((rs1_used_ID && (rs1_ID == rd_EX)) ||
                     (rs2_used_ID && (rs2_ID == rd_EX)));
        any_stall = miss_stall || div_stall;
    end

    // Next-state logic; a miss seen while dividing is serviced without leaving DIV.
    always_comb begin
        state_d = state_q;
        if (rst) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (dcache_miss && !dcache_done) begin
                        state_d = ST_MISS;
                    end else if (div_start_EX && !dcache_miss && !div_done) begin
                        state_d = ST_DIV;
                    end
                end
                ST_MISS: begin
                    if (dcache_done) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Watchdog: consecutive stall cycles, saturating; error is sticky until reset.
    always_comb begin
        stall_cnt_d = '0;
        stall_err_d = stall_err_q;
        if (rst) begin
            stall_cnt_d = '0;
            stall_err_d = 1'b0;
        end else if (any_stall) begin
            if (stall_cnt_q == CNT_W'(TIMEOUT)) begin
                stall_err_d = 1'b1;
            end
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        stall_cnt_q <= stall_cnt_d;
        stall_err_q <= stall_err_d;
    end

    assign stall_err = stall_err_q;

    // Stage controls in priority order: reset, miss, divide, branch, load-use, jal.
    always_comb begin
        bubbleF = 1'b0;
        bubbleD = 1'b0;
        bubbleE = 1'b0;
        bubbleM = 1'b0;
        bubbleW = 1'b0;
        flushF  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        flushW  = 1'b0;
        if (rst) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else if (miss_stall) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            bubbleM = 1'b1;
            flushW  = 1'b1;
        end else if (div_stall) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            bubbleE = 1'b1;
            flushM  = 1'b1;
        end else if (br_taken_EX) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use) begin
            bubbleF = 1'b1;
            bubbleD = 1'b1;
            flushE  = 1'b1;
        end else if (jal_ID) begin
            flushD = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
    logic              redirect;

    // Flushes caused by reset or load-use are not redirects and are not counted.
    always_comb begin
        redirect     = !rst && !any_stall && (br_taken_EX || (!load_use && jal_ID));
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (rst) begin
            perf_stall_d = '0;
            perf_flush_d = '0;
        end else begin
            if (bubbleF) begin
                perf_stall_d = perf_stall_q + PERF_W'(1);
            end
            if (redirect) begin
                perf_flush_d = perf_flush_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        perf_stall_q <= perf_stall_d;
        perf_flush_q <= perf_flush_d;
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver queues expected controls each cycle, a monitor compares them.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
    logic        rs1_used_ID = 0, rs2_used_ID = 0, load_EX = 0, br_taken_EX = 0, jal_ID = 0;
    logic        dcache_miss = 0, dcache_done = 0, div_start_EX = 0, div_done = 0;
    logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
    logic        flushF, flushD, flushE, flushM, flushW, stall_err;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .load_EX(load_EX), .br_taken_EX(br_taken_EX), .jal_ID(jal_ID),
        .dcache_miss(dcache_miss), .dcache_done(dcache_done),
        .div_start_EX(div_start_EX), .div_done(div_done),
        .bubbleF(bubbleF), .bubbleD(bubbleD), .bubbleE(bubbleE), .bubbleM(bubbleM), .bubbleW(bubbleW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .stall_err(stall_err), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    // Vector order: {bF,bD,bE,bM,bW,fF,fD,fE,fM,fW,err}
    localparam logic [10:0] BF = 11'h400, BD = 11'h200, BE = 11'h100, BM = 11'h080;
    localparam logic [10:0] FF = 11'h020, FD = 11'h010, FE = 11'h008, FM = 11'h004, FW = 11'h002;
    localparam logic [10:0] ER = 11'h001;
    localparam logic [10:0] RSTV = FF | FD | FE | FM | FW;
    localparam logic [10:0] LU   = BF | BD | FE;
    localparam logic [10:0] BR   = FD | FE;
    localparam logic [10:0] JAL  = FD;
    localparam logic [10:0] MISS = BF | BD | BE | BM | FW;
    localparam logic [10:0] DIV  = BF | BD | BE | FM;
    localparam logic [10:0] ALL  = 11'h7FF;
    localparam logic [10:0] NOER = 11'h7FE;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_PS = 32'd7;
    localparam logic [31:0] EXP_PF = 32'd2;
`else
    localparam logic [31:0] EXP_PS = 32'd0;
    localparam logic [31:0] EXP_PF = 32'd0;
`endif

    typedef struct {
        string       name;
        logic [10:0] exp;
        logic [10:0] mask;
        bit          chk_perf;
        logic [31:0] exp_ps;
        logic [31:0] exp_pf;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: one expected entry per driven cycle, sampled mid-cycle.
    initial begin
        exp_t        e;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
                       flushF, flushD, flushE, flushM, flushW, stall_err};
                n_checks++;
                if ((act & e.mask) !== (e.exp & e.mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b (mask %b)", e.name, act, e.exp, e.mask);
                end
                if (e.chk_perf) begin
                    n_checks++;
                    if (perf_stall_cnt !== e.exp_ps) begin
                        n_fail++;
                        $display("FAIL %s perf_stall_cnt: got %0d required %0d", e.name, perf_stall_cnt, e.exp_ps);
                    end
                    n_checks++;
                    if (perf_flush_cnt !== e.exp_pf) begin
                        n_fail++;
                        $display("FAIL %s perf_flush_cnt: got %0d required %0d", e.name, perf_flush_cnt, e.exp_pf);
                    end
                end
            end
        end
    end

    task automatic step_p(input string nm, input logic [10:0] exp, input logic [10:0] mask,
                          input bit chk, input logic [31:0] ps, input logic [31:0] pf);
        exp_t e;
        e.name = nm; e.exp = exp; e.mask = mask; e.chk_perf = chk; e.exp_ps = ps; e.exp_pf = pf;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string nm, input logic [10:0] exp, input logic [10:0] mask);
        step_p(nm, exp, mask, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic clear_inputs();
        rs1_ID = '0; rs2_ID = '0; rd_EX = '0;
        rs1_used_ID = 0; rs2_used_ID = 0; load_EX = 0; br_taken_EX = 0; jal_ID = 0;
        dcache_miss = 0; dcache_done = 0; div_start_EX = 0; div_done = 0;
    endtask

    task automatic do_reset(input string nm);
        clear_inputs();
        rst = 1;
        step(nm, RSTV, NOER);
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(posedge clk);
        #1;
        step("reset_flush", RSTV, ALL);
        rst = 0;
        step_p("reset_idle", 11'h0, ALL, 1'b1, 32'd0, 32'd0);

        // Load-use and redirect priority
        load_EX = 1; rd_EX = 5; rs2_ID = 5; rs2_used_ID = 1; rs1_ID = 3; rs1_used_ID = 1;
        step("lu_rs2", LU, ALL);
        load_EX = 0;
        step("lu_one_cycle", 11'h0, ALL);
        load_EX = 1; rd_EX = 0; rs2_ID = 0;
        step("lu_rd0", 11'h0, ALL);
        rd_EX = 3; rs2_ID = 5;
        step("lu_rs1", LU, ALL);
        rs1_used_ID = 0;
        step("lu_rs1_unused", 11'h0, ALL);
        rs1_used_ID = 1; br_taken_EX = 1;
        step("br_over_lu", BR, ALL);
        br_taken_EX = 0; jal_ID = 1;
        step("lu_over_jal", LU, ALL);
        load_EX = 0;
        step("jal_alone", JAL, ALL);
        br_taken_EX = 1;
        step("br_over_jal", BR, ALL);
        clear_inputs();

        // Miss for cycles 0-3, done at 4, branch held throughout
        dcache_miss = 1; br_taken_EX = 1;
        for (int c = 0; c < 4; c++) step($sformatf("miss_c%0d", c), MISS, ALL);
        dcache_done = 1;
        step("miss_done_br", BR, ALL);
        clear_inputs();
        step("miss_back_run", 11'h0, ALL);

        // Divide from cycle 0, done at 10
        div_start_EX = 1;
        step("div_c0", DIV, NOER);
        div_start_EX = 0;
        for (int c = 1; c < 10; c++) step($sformatf("div_c%0d", c), DIV, NOER);
        div_done = 1;
        step("div_done", 11'h0, NOER);
        div_done = 0;
        step("div_back_run", 11'h0, NOER);
        do_reset("rst_after_div");

        div_start_EX = 1; div_done = 1;
        step("div_same_cycle", 11'h0, ALL);
        clear_inputs();
        step("div_same_no_state", 11'h0, ALL);

        // Divide with a miss in cycles 3-5 (done at 6)
        div_start_EX = 1;
        step("dm_c0", DIV, NOER);
        div_start_EX = 0;
        for (int c = 1; c < 10; c++) begin
            dcache_miss = (c >= 3 && c <= 6);
            dcache_done = (c == 6);
            step($sformatf("dm_c%0d", c), (c >= 3 && c <= 5) ? MISS : DIV, NOER);
        end
        dcache_miss = 0; dcache_done = 0; div_done = 1;
        step("dm_div_done", 11'h0, NOER);
        div_done = 0;
        step("dm_back_run", 11'h0, NOER);

        // Performance counters: 3 load-use cycles, a 4-cycle miss, 2 branches
        do_reset("rst_perf");
        rd_EX = 7; rs1_ID = 7; rs1_used_ID = 1;
        load_EX = 1; step("perf_lu0", LU, ALL);
        load_EX = 0; step("perf_gap", 11'h0, ALL);
        load_EX = 1; step("perf_lu1", LU, ALL);
        step("perf_lu2", LU, ALL);
        clear_inputs();
        dcache_miss = 1;
        for (int c = 0; c < 4; c++) step($sformatf("perf_miss%0d", c), MISS, ALL);
        dcache_done = 1; step("perf_miss_done", 11'h0, ALL);
        clear_inputs();
        br_taken_EX = 1; step("perf_br0", BR, ALL);
        br_taken_EX = 0; step("perf_gap2", 11'h0, ALL);
        br_taken_EX = 1; step("perf_br1", BR, ALL);
        br_taken_EX = 0;
        step_p("perf_counts", 11'h0, ALL, 1'b1, EXP_PS, EXP_PF);
        do_reset("rst_perf_clear");
        step_p("perf_cleared", 11'h0, ALL, 1'b1, 32'd0, 32'd0);

        // Reset in the middle of a miss aborts it
        dcache_miss = 1;
        step("abort_miss", MISS, ALL);
        rst = 1; dcache_miss = 0;
        step("abort_rst", RSTV, ALL);
        rst = 0;
        step("abort_run", 11'h0, ALL);

        // Watchdog with TIMEOUT=8: error from cycle 9, sticky past stall end
        dcache_miss = 1;
        for (int c = 0; c < 12; c++)
            step($sformatf("wd_c%0d", c), MISS | ((c >= 9) ? ER : 11'h0), ALL);
        dcache_done = 1;
        step("wd_done", ER, ALL);
        clear_inputs();
        step("wd_sticky", ER, ALL);
        rst = 1;
        step("wd_rst", RSTV | ER, ALL);
        rst = 0;
        step("wd_cleared", 11'h0, ALL);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending required 0", sb_q.size());
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
